// File: rtl/fir_pkg.sv
// Shared filter package: control-state encoding and the width helpers used to
// size folded FIR datapaths.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  // Ceiling log2, never below 1 so that it can always size a vector.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned fold_of(input int unsigned taps);
    return (taps + 1) / 2;
  endfunction

  function automatic int unsigned pre_width(input int unsigned wl);
    return wl + 1;
  endfunction

  function automatic int unsigned prod_width(input int unsigned wl, input int unsigned cwl);
    return wl + 1 + cwl;
  endfunction

  // Headroom of clog2(fold) bits covers the worst-case sum of fold products.
  function automatic int unsigned acc_width(input int unsigned wl, input int unsigned cwl,
                                            input int unsigned fold);
    return wl + 1 + cwl + clog2_min1(fold);
  endfunction

endpackage

// File: rtl/sym_fir_serial_if.sv
// Sample, result and coefficient-write ports of the serial symmetric FIR.
interface sym_fir_serial_if #(
  parameter int unsigned WL     = 14,
  parameter int unsigned CWL    = 14,
  parameter int unsigned MAC_WL = 20,
  parameter int unsigned AW     = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [WL-1:0]     in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [MAC_WL-1:0] out_data;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [CWL-1:0]    coef_wdata;
  logic                     coef_err;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, coef_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, coef_err
  );
endinterface

// File: rtl/fir_round_sat.sv
// Half-up rounding arithmetic right shift followed by two's-complement
// saturation to OUT_WL bits; purely combinational.
module fir_round_sat #(
  parameter int unsigned IN_WL  = 34,
  parameter int unsigned OUT_WL = 20,
  parameter int unsigned SHIFT  = 13
) (
  input  logic signed [IN_WL-1:0]  din,
  output logic signed [OUT_WL-1:0] dout_c
);
  // One extra bit so the rounding add can never wrap.
  localparam int unsigned EW = IN_WL + 1;
  localparam logic signed [EW-1:0] HALF =
    (SHIFT == 0) ? '0 : EW'(64'd1 << ((SHIFT == 0) ? 0 : SHIFT - 1));
  localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_WL+1){1'b0}}, {(OUT_WL-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = {{(EW-OUT_WL+1){1'b1}}, {(OUT_WL-1){1'b0}}};

  logic signed [EW-1:0] sum_c;
  logic signed [EW-1:0] shr_c;

  always_comb begin
    sum_c = EW'(din) + HALF;
    shr_c = sum_c >>> SHIFT;
    if (shr_c > MAX_V) begin
      dout_c = OUT_WL'(MAX_V);
    end else if (shr_c < MIN_V) begin
      dout_c = OUT_WL'(MIN_V);
    end else begin
      dout_c = OUT_WL'(shr_c);
    end
  end
endmodule

// File: rtl/sym_fir_serial.sv
// Odd-length symmetric FIR: one pre-adder and one multiplier swept over the
// FOLD stored coefficients, one result per accepted sample.
module sym_fir_serial
  import fir_pkg::*;
#(
  parameter int unsigned WL     = 14,
  parameter int unsigned CWL    = 14,
  parameter int unsigned MAC_WL = 20,
  parameter int unsigned TAPS   = 37,
  parameter int unsigned SHIFT  = 13
) (
  input logic             clk,
  input logic             rst_n,
  sym_fir_serial_if.slave bus
);
  localparam int unsigned FOLD  = fold_of(TAPS);
  localparam int unsigned AW    = clog2_min1(FOLD);
  localparam int unsigned TW    = clog2_min1(TAPS);
  localparam int unsigned PW    = pre_width(WL);
  localparam int unsigned PRW   = prod_width(WL, CWL);
  localparam int unsigned ACC_W = acc_width(WL, CWL, FOLD);

  fir_state_e               state_q, state_d;
  logic signed [WL-1:0]     x_q [TAPS];
  logic signed [WL-1:0]     x_d [TAPS];
  logic signed [CWL-1:0]    c_q [FOLD];
  logic signed [CWL-1:0]    c_d [FOLD];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]            k_q, k_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [MAC_WL-1:0] out_data_q, out_data_d;
  logic                     coef_err_q, coef_err_d;
  logic                     in_ready_q, in_ready_d;

  logic                     centre_c;
  logic [TW-1:0]            tap_a_c, tap_b_c;
  logic signed [WL-1:0]     xa_c, xb_c;
  logic signed [CWL-1:0]    coef_c;
  logic signed [PW-1:0]     pre_c;
  logic signed [PRW-1:0]    prod_c;
  logic signed [ACC_W-1:0]  acc_sum_c;
  logic signed [MAC_WL-1:0] rs_c;
  logic                     coef_ok_c;

  // Shared pre-add / multiply / accumulate; the centre tap has no mirror partner.
  always_comb begin
    centre_c  = (k_q == AW'(FOLD - 1));
    tap_a_c   = TW'(k_q);
    tap_b_c   = TW'(TAPS - 1) - TW'(k_q);
    xa_c      = x_q[tap_a_c];
    xb_c      = centre_c ? '0 : x_q[tap_b_c];
    coef_c    = c_q[k_q];
    pre_c     = PW'(xa_c) + PW'(xb_c);
    prod_c    = PRW'(pre_c) * PRW'(coef_c);
    acc_sum_c = acc_q + ACC_W'(prod_c);
  end

  fir_round_sat #(
    .IN_WL  (ACC_W),
    .OUT_WL (MAC_WL),
    .SHIFT  (SHIFT)
  ) u_round_sat (
    .din    (acc_sum_c),
    .dout_c (rs_c)
  );

  // Next-state, coefficient port and output logic.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    c_d         = c_q;
    acc_d       = acc_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    coef_err_d  = 1'b0;

    coef_ok_c = (state_q == ST_IDLE) && ({1'b0, bus.coef_addr} < (AW + 1)'(FOLD));
    if (bus.coef_we) begin
      if (coef_ok_c) begin
        c_d[bus.coef_addr] = bus.coef_wdata;
      end else begin
        coef_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          x_d[0] = bus.in_data;
          for (int unsigned i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
          acc_d   = '0;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_sum_c;
        if (centre_c) begin
          state_d     = ST_OUT;
          out_valid_d = 1'b1;
          out_data_d  = rs_c;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '{default: '0};
      c_q         <= '{default: '0};
      acc_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      coef_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      coef_err_q  <= coef_err_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.coef_err  = coef_err_q;

endmodule

// File: tb/tb_sym_fir_serial.sv
// Scoreboard bench for sym_fir_serial (MAC_WL=16 so saturation is reachable).
module tb_sym_fir_serial;

  localparam int WL     = 14;
  localparam int CWL    = 14;
  localparam int MAC_WL = 16;
  localparam int TAPS   = 37;
  localparam int SHIFT  = 13;
  localparam int FOLD   = 19;
  localparam int AW     = 5;
  localparam int LAT    = FOLD + 1;

  typedef struct {
    longint v;
    int     hs;
    bit     lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sym_fir_serial_if #(.WL(WL), .CWL(CWL), .MAC_WL(MAC_WL), .AW(AW)) bus ();

  sym_fir_serial #(
    .WL(WL), .CWL(CWL), .MAC_WL(MAC_WL), .TAPS(TAPS), .SHIFT(SHIFT)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t   sbq[$];
  longint mx[TAPS];
  longint mc[FOLD];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Direct (unfolded) convolution over the full symmetric coefficient set.
  function automatic longint model_out();
    longint s, r, lim;
    int ci;
    s = 0;
    for (int k = 0; k < TAPS; k++) begin
      ci = (k < FOLD) ? k : TAPS - 1 - k;
      s += mc[ci] * mx[k];
    end
    r   = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    lim = longint'(1) <<< (MAC_WL - 1);
    if (r > lim - 1) r = lim - 1;
    if (r < -lim) r = -lim;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) mx[k] = 0;
    for (int k = 0; k < FOLD; k++) mc[k] = 0;
  endtask

  task automatic send(input longint d, input bit hand, input longint hv, input bit lat);
    bit   ok;
    exp_t e;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = WL'(d);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = d;
      e.v   = hand ? hv : model_out();
      e.hs  = cyc;
      e.lat = lat;
      sbq.push_back(e);
    end else begin
      chk("accept_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic coef_write(input int a, input longint v, input bit exp_err);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AW'(a);
    bus.coef_wdata = CWL'(v);
    tick();
    bus.coef_we = 1'b0;
    if (!exp_err) mc[a] = v;
    chk("coef_err_pulse", bus.coef_err, exp_err);
    tick();
    chk("coef_err_clear", bus.coef_err, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 6000; i++) begin
      if (sbq.size() == 0) break;
      tick();
    end
    chk("drain_timeout", sbq.size(), 0);
    tick();
    tick();
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = held low.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency on the rising edge of out_valid, data on each handshake.
  initial begin
    bit   pv;
    exp_t e;
    pv = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0;
      end else begin
        if (bus.out_valid && !pv) begin
          if (sbq.size() == 0) chk("spurious_out", 1, 0);
          else if (sbq[0].lat) chk("latency", cyc - sbq[0].hs, LAT);
        end
        if (bus.out_valid && bus.out_ready && sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("out_data", bus.out_data, e.v);
        end
        pv = bus.out_valid;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit     got;
    longint d1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    model_reset();

    // Reset values.
    repeat (3) tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_coef_err", bus.coef_err, 0);
    rst_n = 1'b1;
    chk("rst_in_ready", bus.in_ready, 1);
    tick();
    chk("rst_in_ready_after", bus.in_ready, 1);

    // Impulse through the centre tap: 8191*8191 rounds to 8190 at output 19.
    coef_write(18, 8191, 0);
    for (int i = 0; i < TAPS; i++) send((i == 0) ? 8191 : 0, 1, (i == 18) ? 8190 : 0, 1);
    drain();

    // Write during MAC (k=5) and to address 19 in IDLE are both dropped.
    send(0, 1, 0, 1);
    repeat (5) tick();
    coef_write(18, 0, 1);
    drain();
    coef_write(19, 5, 1);
    for (int i = 0; i < FOLD; i++) send((i == 0) ? 8191 : 0, 1, (i == 18) ? 8190 : 0, 1);
    drain();

    // Saturation with every coefficient at 8191.
    for (int a = 0; a < FOLD; a++) coef_write(a, 8191, 0);
    for (int i = 0; i < 40; i++) send(8191, i >= 36, 32767, 0);
    for (int i = 0; i < 40; i++) send(-8192, i >= 36, -32768, 0);
    drain();

    // Backpressure: result held for 10 cycles, next sample waits.
    for (int a = 0; a < FOLD; a++) coef_write(a, longint'($urandom_range(0, 2047)) - 1024, 0);
    rdy_mode = 2;
    send(3000, 0, 0, 0);
    got = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.out_valid) begin
        got = 1;
        break;
      end
    end
    chk("bp_valid_seen", got, 1);
    d1 = -1234;
    bus.in_valid = 1'b1;
    bus.in_data  = WL'(d1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      if (sbq.size() != 0) chk("bp_out_data", bus.out_data, sbq[0].v);
      else chk("bp_queue", 0, 1);
    end
    rdy_mode = 0;
    send(d1, 0, 0, 0);
    drain();

    // Random gaps and random out_ready against the model.
    rdy_mode = 1;
    for (int n = 0; n < 100; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(longint'($urandom_range(0, 16383)) - 8192, 0, 0, 0);
    end
    drain();
    rdy_mode = 0;
    drain();

    // Reset at MAC k=9: result discarded, state fully cleared.
    send(5000, 0, 0, 0);
    repeat (9) tick();
    rst_n = 1'b0;
    sbq.delete();
    model_reset();
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 25; i++) begin
      tick();
      if (i % 8 == 0) chk("mid_rst_no_out", bus.out_valid, 0);
    end
    coef_write(0, 8191, 0);
    send(100, 1, 100, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
